// File: rtl/ili9341_pkg.sv
// Shared constants, state encoding and byte helpers for the ILI9341 rectangle framer.
// The optional ILI9341_CLIP_EN macro is consumed by ili9341_rect_framer.
package ili9341_pkg;

   localparam int COORD_W  = 9;
   localparam int PIXCNT_W = 17;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CASET_CMD,
      ST_CASET_PAR,
      ST_PASET_CMD,
      ST_PASET_PAR,
      ST_RAMWR_CMD,
      ST_PIX_HI,
      ST_PIX_LO,
      ST_DONE,
      ST_ERR
   } frameState_t;

   // Address-window parameter byte idx of {start[15:0], end[15:0]}, big-endian.
   function automatic logic [7:0] parByte(
      input logic [1:0]         idx,
      input logic [COORD_W-1:0] a,
      input logic [COORD_W-1:0] b
   );
      logic [15:0] wa;
      logic [15:0] wb;
      logic [7:0]  res;
      wa = 16'(a);
      wb = 16'(b);
      unique case (idx)
         2'd0:    res = wa[15:8];
         2'd1:    res = wa[7:0];
         2'd2:    res = wb[15:8];
         default: res = wb[7:0];
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ili9341_byte_reg.sv
// Output holding register for the framer byte stream.
// Loads a new byte or drops valid once the held byte has been taken.
module ili9341_byte_reg
   import ili9341_pkg::*;
(
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       load,
   input  logic [7:0] ldData,
   input  logic       ldDc,
   input  logic       ready,
   output logic       valid,
   output logic [7:0] data,
   output logic       dc
);

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         valid <= 1'b0;
         data  <= 8'h00;
         dc    <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= ldData;
         dc    <= ldDc;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ili9341_rect_framer.sv
// Fill-rectangle request to ILI9341 CASET/PASET/RAMWR byte stream framer.
// Define ILI9341_CLIP_EN to clamp out-of-range coordinates instead of rejecting.
module ili9341_rect_framer
   import ili9341_pkg::*;
#(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [COORD_W-1:0] req_x0,
   input  logic [COORD_W-1:0] req_x1,
   input  logic [COORD_W-1:0] req_y0,
   input  logic [COORD_W-1:0] req_y1,
   input  logic [15:0]        req_color,
   output logic               byte_valid,
   input  logic               byte_ready,
   output logic [7:0]         byte_data,
   output logic               byte_dc,
   output logic               done,
   output logic               err
);

   localparam logic [COORD_W-1:0] XMAX = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] YMAX = COORD_W'(HEIGHT - 1);

   frameState_t state, stNext;
   logic [1:0]  idx, idxNext;
   logic [PIXCNT_W-1:0] cnt, cntNext, nReq;
   logic [COORD_W-1:0]  cx0, cx1, cy0, cy1;
   logic [COORD_W-1:0]  x0q, x1q, y0q, y1q;
   logic [15:0]         colorQ;
   logic [COORD_W:0]    dx, dy;
   logic rangeOk, orderOk, reqOk;
   logic accept, xfer, load, ldDc;
   logic [7:0] ldData;
   logic bValid;

`ifdef ILI9341_CLIP_EN
   always_comb begin
      cx0 = (req_x0 > XMAX) ? XMAX : req_x0;
      cx1 = (req_x1 > XMAX) ? XMAX : req_x1;
      cy0 = (req_y0 > YMAX) ? YMAX : req_y0;
      cy1 = (req_y1 > YMAX) ? YMAX : req_y1;
      rangeOk = 1'b1;
   end
`else
   always_comb begin
      cx0 = req_x0;
      cx1 = req_x1;
      cy0 = req_y0;
      cy1 = req_y1;
      rangeOk = (req_x0 <= XMAX) && (req_x1 <= XMAX) &&
                (req_y0 <= YMAX) && (req_y1 <= YMAX);
   end
`endif

   // Pixel count is only meaningful when the order check passes.
   always_comb begin
      orderOk = (cx1 >= cx0) && (cy1 >= cy0);
      reqOk   = rangeOk && orderOk;
      dx      = {1'b0, cx1} - {1'b0, cx0} + (COORD_W+1)'(1);
      dy      = {1'b0, cy1} - {1'b0, cy0} + (COORD_W+1)'(1);
      nReq    = PIXCNT_W'(dx) * PIXCNT_W'(dy);
   end

   assign req_ready = (state == ST_IDLE) || (state == ST_DONE);
   assign accept    = req_valid && req_ready;
   assign xfer      = bValid && byte_ready;
   assign done      = (state == ST_DONE);
   assign err       = (state == ST_ERR);
   assign byte_valid = bValid;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state <= ST_IDLE;
         idx   <= 2'd0;
         cnt   <= '0;
      end else begin
         state <= stNext;
         idx   <= idxNext;
         cnt   <= cntNext;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         x0q    <= '0;
         x1q    <= '0;
         y0q    <= '0;
         y1q    <= '0;
         colorQ <= '0;
      end else if (accept) begin
         x0q    <= cx0;
         x1q    <= cx1;
         y0q    <= cy0;
         y1q    <= cy1;
         colorQ <= req_color;
      end
   end

   // State names the byte currently held in the output register.
   always_comb begin
      stNext  = state;
      idxNext = idx;
      cntNext = cnt;
      load    = 1'b0;
      ldData  = 8'h00;
      ldDc    = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            stNext = ST_IDLE;
            if (accept) begin
               if (reqOk) begin
                  stNext  = ST_CASET_CMD;
                  load    = 1'b1;
                  ldData  = CMD_CASET;
                  cntNext = nReq;
                  idxNext = 2'd0;
               end else begin
                  stNext = ST_ERR;
               end
            end
         end
         ST_ERR: stNext = ST_IDLE;
         ST_CASET_CMD: if (xfer) begin
            load    = 1'b1;
            ldData  = parByte(2'd0, x0q, x1q);
            ldDc    = 1'b1;
            idxNext = 2'd1;
            stNext  = ST_CASET_PAR;
         end
         ST_CASET_PAR: if (xfer) begin
            load = 1'b1;
            if (idx == 2'd0) begin
               ldData = CMD_PASET;
               stNext = ST_PASET_CMD;
            end else begin
               ldData  = parByte(idx, x0q, x1q);
               ldDc    = 1'b1;
               idxNext = idx + 2'd1;
            end
         end
         ST_PASET_CMD: if (xfer) begin
            load    = 1'b1;
            ldData  = parByte(2'd0, y0q, y1q);
            ldDc    = 1'b1;
            idxNext = 2'd1;
            stNext  = ST_PASET_PAR;
         end
         ST_PASET_PAR: if (xfer) begin
            load = 1'b1;
            if (idx == 2'd0) begin
               ldData = CMD_RAMWR;
               stNext = ST_RAMWR_CMD;
            end else begin
               ldData  = parByte(idx, y0q, y1q);
               ldDc    = 1'b1;
               idxNext = idx + 2'd1;
            end
         end
         ST_RAMWR_CMD, ST_PIX_LO: if (xfer) begin
            if (state == ST_PIX_LO) begin
               cntNext = cnt - PIXCNT_W'(1);
            end
            if (state == ST_PIX_LO && cnt == PIXCNT_W'(1)) begin
               stNext = ST_DONE;
            end else begin
               load   = 1'b1;
               ldData = colorQ[15:8];
               ldDc   = 1'b1;
               stNext = ST_PIX_HI;
            end
         end
         ST_PIX_HI: if (xfer) begin
            load   = 1'b1;
            ldData = colorQ[7:0];
            ldDc   = 1'b1;
            stNext = ST_PIX_LO;
         end
         default: stNext = ST_IDLE;
      endcase
   end

   ili9341_byte_reg uByteReg (
      .CLK_I  (CLK_I),
      .RST_I  (RST_I),
      .load   (load),
      .ldData (ldData),
      .ldDc   (ldDc),
      .ready  (byte_ready),
      .valid  (bValid),
      .data   (byte_data),
      .dc     (byte_dc)
   );

endmodule

// File: tb/tb_ili9341_rect_framer.sv
// Self-checking bench for ili9341_rect_framer: scoreboard of expected
// {dc,byte} pairs, directed requests, stalls, rejects and async reset.
module tb_ili9341_rect_framer;

   localparam int W = 240;
   localparam int H = 320;

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [8:0]  req_x0 = '0, req_x1 = '0, req_y0 = '0, req_y1 = '0;
   logic [15:0] req_color = '0;
   logic        byte_valid;
   logic        byte_ready = 1'b1;
   logic [7:0]  byte_data;
   logic        byte_dc;
   logic        done;
   logic        err;

   int passCnt = 0;
   int totCnt  = 0;
   int doneCnt = 0;
   int errCnt  = 0;
   logic [8:0] q [$];
   logic rndReady = 1'b0;
   logic stallPrev = 1'b0;
   logic [8:0] stallByte = '0;

   ili9341_rect_framer #(.WIDTH(W), .HEIGHT(H)) dut (
      .CLK_I      (CLK_I),
      .RST_I      (RST_I),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x0     (req_x0),
      .req_x1     (req_x1),
      .req_y0     (req_y0),
      .req_y1     (req_y1),
      .req_color  (req_color),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_data  (byte_data),
      .byte_dc    (byte_dc),
      .done       (done),
      .err        (err)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      totCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   always @(posedge CLK_I) begin
      #1;
      byte_ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: stall stability, scoreboard pops, done/err pulse counts.
   always @(negedge CLK_I) begin
      if (!RST_I) begin
         if (stallPrev) begin
            chk("valid_hold", 32'(byte_valid), 32'd1);
            chk("stall_hold", 32'({byte_dc, byte_data}), 32'(stallByte));
         end
         if (done) doneCnt++;
         if (err) errCnt++;
         if (byte_valid && byte_ready) begin
            if (q.size() == 0) begin
               chk("extra_byte", 32'({byte_dc, byte_data}), 32'h1FF);
            end else begin
               chk("stream_byte", 32'({byte_dc, byte_data}),
                   32'(q.pop_front()));
            end
         end
         stallPrev = byte_valid && !byte_ready;
         stallByte = {byte_dc, byte_data};
      end else begin
         stallPrev = 1'b0;
      end
   end

   function automatic logic [8:0] clipv(input logic [8:0] v,
                                        input int lim);
`ifdef ILI9341_CLIP_EN
      if (int'(v) >= lim) return 9'(lim - 1);
`endif
      return v;
   endfunction

   // Builds the expected stream; returns 1 if the request should be accepted.
   task automatic sendReq(input logic [8:0] x0, y0, x1, y1,
                          input logic [15:0] c, output logic ok);
      logic [8:0] a0, a1, b0, b1;
      int n, k;
      a0 = clipv(x0, W);
      a1 = clipv(x1, W);
      b0 = clipv(y0, H);
      b1 = clipv(y1, H);
      ok = (int'(a0) < W) && (int'(a1) < W) && (int'(b0) < H) &&
           (int'(b1) < H) && (a1 >= a0) && (b1 >= b0);
      if (ok) begin
         n = (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1);
         q.push_back(9'h02A);
         q.push_back({1'b1, 7'd0, a0[8]});
         q.push_back({1'b1, a0[7:0]});
         q.push_back({1'b1, 7'd0, a1[8]});
         q.push_back({1'b1, a1[7:0]});
         q.push_back(9'h02B);
         q.push_back({1'b1, 7'd0, b0[8]});
         q.push_back({1'b1, b0[7:0]});
         q.push_back({1'b1, 7'd0, b1[8]});
         q.push_back({1'b1, b1[7:0]});
         q.push_back(9'h02C);
         for (int i = 0; i < n; i++) begin
            q.push_back({1'b1, c[15:8]});
            q.push_back({1'b1, c[7:0]});
         end
      end
      @(posedge CLK_I);
      #1;
      req_valid = 1'b1;
      req_x0 = x0;
      req_y0 = y0;
      req_x1 = x1;
      req_y1 = y1;
      req_color = c;
      for (k = 0; k < 200; k++) begin
         @(negedge CLK_I);
         if (req_ready) break;
      end
      chk("req_accept", 32'(k < 200), 32'd1);
      @(posedge CLK_I);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic waitEnd(input logic ok, input int budget);
      int d0, e0, k;
      d0 = doneCnt;
      e0 = errCnt;
      for (k = 0; k < budget; k++) begin
         @(negedge CLK_I);
         if (doneCnt != d0 || errCnt != e0) break;
      end
      chk("end_timeout", 32'(k < budget), 32'd1);
      repeat (2) @(negedge CLK_I);
      chk("done_pulses", 32'(doneCnt - d0), 32'(ok ? 1 : 0));
      chk("err_pulses", 32'(errCnt - e0), 32'(ok ? 0 : 1));
      chk("queue_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic runReq(input logic [8:0] x0, y0, x1, y1,
                         input logic [15:0] c, input int budget);
      logic ok;
      sendReq(x0, y0, x1, y1, c, ok);
      waitEnd(ok, budget);
   endtask

   initial begin
      logic ok;
      int k;
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_byte_valid", 32'(byte_valid), 32'd0);
      chk("rst_byte_data", 32'(byte_data), 32'd0);
      chk("rst_byte_dc", 32'(byte_dc), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge CLK_I);
      RST_I = 1'b0;

      // Single pixel: 13 bytes then done in the 14th cycle.
      sendReq(9'd5, 9'd7, 9'd5, 9'd7, 16'hF800, ok);
      chk("single_ok", 32'(ok), 32'd1);
      for (k = 1; k <= 30; k++) begin
         @(negedge CLK_I);
         if (k == 1) chk("first_valid", 32'(byte_valid), 32'd1);
         if (done) break;
      end
      chk("done_cycle", 32'(k), 32'd14);
      chk("single_queue", 32'(q.size()), 32'd0);

      // Corner pixel exercising the high coordinate byte.
      runReq(9'd239, 9'd319, 9'd239, 9'd319, 16'hA55A, 100);

      // Large band reaching the last row and column.
      runReq(9'd0, 9'd240, 9'd239, 9'd319, 16'h07E0, 60000);

      // Random stalls on a 4x3 rectangle.
      rndReady = 1'b1;
      runReq(9'd2, 9'd3, 9'd5, 9'd5, 16'h1F3C, 2000);
      rndReady = 1'b0;

      // Reversed x range is rejected.
      sendReq(9'd10, 9'd0, 9'd3, 9'd0, 16'hFFFF, ok);
      chk("rev_model", 32'(ok), 32'd0);
      @(negedge CLK_I);
      chk("rev_err", 32'(err), 32'd1);
      chk("rev_no_byte", 32'(byte_valid), 32'd0);
      @(negedge CLK_I);
      chk("rev_err_drop", 32'(err), 32'd0);
      chk("rev_ready", 32'(req_ready), 32'd1);
      chk("rev_no_byte2", 32'(byte_valid), 32'd0);

      // Out-of-range x1: clipped or rejected depending on build.
      runReq(9'd0, 9'd0, 9'd300, 9'd0, 16'h0001, 2000);

      // Async reset in the middle of pixel output.
      sendReq(9'd0, 9'd0, 9'd9, 9'd9, 16'h1234, ok);
      for (k = 0; k < 200; k++) begin
         @(negedge CLK_I);
         if (byte_valid && byte_dc && byte_data == 8'h12) break;
      end
      chk("pixhi_reached", 32'(k < 200), 32'd1);
      #2;
      RST_I = 1'b1;
      #1;
      chk("async_rst_valid", 32'(byte_valid), 32'd0);
      chk("async_rst_ready", 32'(req_ready), 32'd1);
      q.delete();
      @(negedge CLK_I);
      RST_I = 1'b0;
      runReq(9'd1, 9'd1, 9'd2, 9'd1, 16'hBEEF, 200);

      $display("%0d/%0d checks passed", passCnt, totCnt);
      $finish;
   end

endmodule
